// File: rtl/gf_pkg.sv
// Shared GF(2^m) types and constants for the exponentiation datapath.
// Holds the controller state enum, field limits and default polynomials.
package gf_pkg;

  localparam int GF_M_MIN = 3;
  localparam int GF_M_MAX = 4;
  localparam int GF_FW    = 4;

  localparam logic [4:0] GF_P3 = 5'b01011;
  localparam logic [4:0] GF_P4 = 5'b10011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SQR,
    S_MUL,
    S_DONE
  } gf_state_e;

  function automatic logic m_legal(
    input logic [2:0] m
  );
    return (m == 3'(GF_M_MIN)) ||
           (m == 3'(GF_M_MAX));
  endfunction

  // Clears element bits at and above m.
  function automatic logic [GF_FW-1:0] mask_m(
    input logic [GF_FW-1:0] x,
    input logic [2:0]       m
  );
    return (m == 3'(GF_M_MIN)) ?
           (x & 4'b0111) : x;
  endfunction

endpackage

// File: rtl/gf_mul_core.sv
// Combinational GF(2^m) multiplier: carry-less product reduced mod p.
// Ports: a, b operands; p full polynomial; m degree; mul m-bit product.
module gf_mul_core
  import gf_pkg::*;
(
  input  logic [GF_FW-1:0] a,
  input  logic [GF_FW-1:0] b,
  input  logic [4:0]       p,
  input  logic [2:0]       m,
  output logic [GF_FW-1:0] mul
);

  localparam int PW = 2*GF_FW-1;

  logic [PW-1:0] prod;

  always_comb begin
    prod = '0;
    for (int i = 0; i < GF_FW; i++) begin
      if (b[i]) prod = prod ^ (PW'(a) << i);
    end
    // Fold high terms down from the top bit.
    for (int k = PW-1; k >= GF_M_MIN; k--) begin
      if ((k >= int'(m)) && prod[k]) begin
        prod = prod ^ (PW'(p) << (k - int'(m)));
      end
    end
    mul = mask_m(prod[GF_FW-1:0], m);
  end

endmodule

// File: rtl/gf_pow_ctrl.sv
// MSB-first square-and-multiply a^e mod p over GF(2^m), m in {3,4}.
// Ports: clk, rst, start, m, p, a, e in; busy, done, err, result out.
module gf_pow_ctrl
  import gf_pkg::*;
#(
  parameter int EW = 4,
  parameter int FW = GF_FW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    m,
  input  logic [4:0]    p,
  input  logic [FW-1:0] a,
  input  logic [EW-1:0] e,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [FW-1:0] result
);

  localparam int IW = (EW > 1) ? $clog2(EW) : 1;

  gf_state_e     state_q, state_d;
  logic [FW-1:0] r_q, r_d;
  logic [IW-1:0] i_q, i_d;
  logic [2:0]    m_q, m_d;
  logic [4:0]    p_q, p_d;
  logic [FW-1:0] a_q, a_d;
  logic [EW-1:0] e_q, e_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [FW-1:0] result_q, result_d;

  logic [FW-1:0] mul_b;
  logic [FW-1:0] mul_out;

  // One multiplier: squares in SQR, multiplies by a in MUL.
  assign mul_b = (state_q == S_MUL) ? a_q : r_q;

  gf_mul_core u_mul (
    .a   (r_q),
    .b   (mul_b),
    .p   (p_q),
    .m   (m_q),
    .mul (mul_out)
  );

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    i_d      = i_q;
    m_d      = m_q;
    p_d      = p_q;
    a_d      = a_q;
    e_d      = e_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d   = m;
          p_d   = p;
          a_d   = mask_m(a, m);
          e_d   = e;
          r_d   = FW'(1);
          i_d   = IW'(EW-1);
          err_d = 1'b0;
          if (m_legal(m)) begin
            state_d = S_SQR;
            busy_d  = 1'b1;
          end else begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            err_d    = 1'b1;
            result_d = '0;
          end
        end
      end
      S_SQR: begin
        r_d = mul_out;
        if (e_q[i_q]) begin
          state_d = S_MUL;
          busy_d  = 1'b1;
        end else if (i_q == '0) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = mul_out;
        end else begin
          i_d    = i_q - IW'(1);
          busy_d = 1'b1;
        end
      end
      S_MUL: begin
        r_d = mul_out;
        if (i_q == '0) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = mul_out;
        end else begin
          i_d     = i_q - IW'(1);
          state_d = S_SQR;
          busy_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      i_q      <= '0;
      m_q      <= '0;
      p_q      <= '0;
      a_q      <= '0;
      e_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      i_q      <= i_d;
      m_q      <= m_d;
      p_q      <= p_d;
      a_q      <= a_d;
      e_q      <= e_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule
